// File: rtl/rs232_rx_pkg.sv
// rs232_rx_pkg: shared RS232 state encodings, parity codes and default bit timing
package rs232_rx_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_BREAK} state_t;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD = 2;
  localparam int CLKS_PER_BIT_DEF = 5208;
endpackage

// File: rtl/rs232_sync.sv
// rs232_sync: 2-flop synchroniser resetting to 1 (clk_i, async active-low rst_i, d_i in, q_o out)
module rs232_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) {s2_q, s1_q} <= 2'b11;
    else {s2_q, s1_q} <= {s1_q, d_i};
  assign q_o = s2_q;
endmodule

// File: rtl/rs232_rx.sv
// rs232_rx: UART receiver; RXD_i -> data_o with valid_o/parity_err_o/frame_err_o strobes and busy_o
module rs232_rx
  import rs232_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY = PARITY_NONE
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       RXD_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic par_q, par_d, valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic rxs, tick, mismatch;
  rs232_sync u_sync (.clk_i(clk_i), .rst_i(rst_i), .d_i(RXD_i), .q_o(rxs));
  assign tick = timer_q == '0;
  assign mismatch = (PARITY == PARITY_NONE) ? 1'b0 : (^shift_q ^ par_q ^ (PARITY == PARITY_ODD));
  always_comb begin
    state_d = state_q;
    timer_d = tick ? timer_q : timer_q - TW'(1);
    idx_d = idx_q;
    shift_d = shift_q;
    par_d = par_q;
    data_d = data_q;
    valid_d = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    unique case (state_q)
      ST_IDLE: if (!rxs) begin
        state_d = ST_START;
        timer_d = HALF;
      end
      ST_START: if (tick) begin
        state_d = rxs ? ST_IDLE : ST_DATA;
        idx_d = 3'd0;
        timer_d = FULL;
      end
      ST_DATA: if (tick) begin
        shift_d[idx_q] = rxs;
        idx_d = idx_q + 3'd1;
        timer_d = FULL;
        if (idx_q == 3'd7) state_d = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
      end
      ST_PAR: if (tick) begin
        par_d = rxs;
        timer_d = FULL;
        state_d = ST_STOP;
      end
      ST_STOP: if (tick) begin
        data_d = shift_q;
        valid_d = rxs;
        perr_d = rxs & mismatch;
        ferr_d = !rxs;
        state_d = rxs ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: if (rxs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      par_q <= par_d;
      data_q <= data_d;
      valid_q <= valid_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
    end
  assign data_o = data_q;
  assign valid_o = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o = ferr_q;
  assign busy_o = state_q != ST_IDLE;
endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx: scoreboard bench driving a no-parity and an even-parity receiver
module tb_rs232_rx;
  localparam int CPB = 8;
  typedef struct {
    logic [7:0] d;
    logic pe;
    logic fe;
    int fall;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd [2];
  logic [7:0] data0, data1;
  logic valid0, valid1, perr0, perr1, ferr0, ferr1, busy0, busy1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t q0[$], q1[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  rs232_rx #(.CLKS_PER_BIT(CPB), .PARITY(0)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .RXD_i(rxd[0]), .data_o(data0), .valid_o(valid0),
    .parity_err_o(perr0), .frame_err_o(ferr0), .busy_o(busy0));
  rs232_rx #(.CLKS_PER_BIT(CPB), .PARITY(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .RXD_i(rxd[1]), .data_o(data1), .valid_o(valid1),
    .parity_err_o(perr1), .frame_err_o(ferr1), .busy_o(busy1));
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask
  task automatic mon(input int w, input logic [7:0] d, input logic v, input logic pe, input logic fe);
    exp_t e;
    int lat;
    lat = (w == 0) ? 2 + CPB / 2 + 9 * CPB + 1 : 2 + CPB / 2 + 10 * CPB + 1;
    if (!v && pe) chk($sformatf("dut%0d_perr_without_valid", w), 1, 0);
    if (v || fe) begin
      if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL dut%0d_unexpected_strobe got valid=%b ferr=%b data=%h want none", w, v, fe, d);
      end else begin
        if (w == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("dut%0d_data", w), int'(d), int'(e.d));
        chk($sformatf("dut%0d_valid", w), int'(v), int'(!e.fe));
        chk($sformatf("dut%0d_ferr", w), int'(fe), int'(e.fe));
        chk($sformatf("dut%0d_perr", w), int'(pe), int'(e.pe));
        chk($sformatf("dut%0d_latency", w), cyc - e.fall, lat);
      end
    end
  endtask
  always @(negedge clk) mon(0, data0, valid0, perr0, ferr0);
  always @(negedge clk) mon(1, data1, valid1, perr1, ferr1);
  task automatic hold(input int w, input logic v, input int n);
    rxd[w] = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input int w, input logic [7:0] d, input logic pb, input logic sb);
    exp_t e;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    e.d = d;
    e.fe = !sb;
    e.pe = (w == 1) && sb && ((ones + int'(pb)) % 2 == 1);
    e.fall = cyc;
    if (w == 0) q0.push_back(e);
    else q1.push_back(e);
    hold(w, 1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(w, d[i], CPB);
    if (w == 1) hold(w, pb, CPB);
    hold(w, sb, CPB);
  endtask
  initial begin
    int bc, w, t;
    logic [7:0] r;
    logic sb;
    rxd[0] = 1'b1;
    rxd[1] = 1'b1;
    #22;
    chk("reset_data0", int'(data0), 0);
    chk("reset_valid0", int'(valid0), 0);
    chk("reset_busy0", int'(busy0), 0);
    chk("reset_ferr1", int'(ferr1), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(0, 1'b1, 4);
    send(0, 8'hA5, 1'b0, 1'b1);
    hold(0, 1'b1, 6);
    bc = 0;
    rxd[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) rxd[0] = 1'b1;
      @(posedge clk);
      #1;
      if (busy0) bc++;
    end
    chk("glitch_busy_seen", int'(bc > 0), 1);
    chk("glitch_busy_short", int'(bc <= 6), 1);
    chk("glitch_busy_end", int'(busy0), 0);
    send(0, 8'h3C, 1'b0, 1'b1);
    send(1, 8'h07, 1'b1, 1'b1);
    send(1, 8'h07, 1'b0, 1'b1);
    hold(1, 1'b1, 4);
    send(0, 8'h55, 1'b0, 1'b0);
    hold(0, 1'b0, 40);
    chk("break_busy", int'(busy0), 1);
    hold(0, 1'b1, 16);
    chk("break_exit_busy", int'(busy0), 0);
    send(0, 8'h00, 1'b0, 1'b1);
    send(0, 8'hFF, 1'b0, 1'b1);
    send(0, 8'h81, 1'b0, 1'b1);
    hold(0, 1'b1, 4);
    r = 8'h96;
    hold(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(0, r[i], CPB);
    hold(0, r[4], CPB / 2);
    rst_n = 1'b0;
    rxd[0] = 1'b1;
    #2;
    chk("midreset_data0", int'(data0), 0);
    chk("midreset_valid0", int'(valid0), 0);
    chk("midreset_perr0", int'(perr0), 0);
    chk("midreset_ferr0", int'(ferr0), 0);
    chk("midreset_busy0", int'(busy0), 0);
    chk("midreset_data1", int'(data1), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(0, 1'b1, CPB);
    send(0, 8'h12, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      w = k % 2;
      r = 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      send(w, r, 1'($urandom), sb);
      hold(w, 1'b1, sb ? $urandom_range(0, 12) : $urandom_range(4, 20));
    end
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("pending_dut0", q0.size(), 0);
    chk("pending_dut1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
